comparatore_seriale: RTL and testbench
======================================

Name: comparatore_seriale

Overview:
- Sequential multi-word magnitude comparator sitting directly downstream of the 4-bit nibble comparator.
- Compares two WIDTH = 4*NIBBLES bit words one nibble per cycle, MSB nibble first.
- Drives the nibble-select index that muxes A/B nibbles into the upstream 4-bit comparator, consumes its one-hot GT/EQ/LT result, and terminates early on the first unequal nibble.
- Exposes a start/busy/done handshake with registered, held results.

Parameters:
- NIBBLES, 4: number of 4-bit nibbles per operand (16-bit words by default); legal range 2..16.
- SEL_W, 2: width of nib_sel; must equal ceil(log2(NIBBLES)).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request a new comparison; sampled only in IDLE.
- nib_gt  input  1  upstream nibble comparator GT for the nibble at nib_sel, same cycle (combinational path).
- nib_eq  input  1  upstream nibble comparator EQ for the nibble at nib_sel.
- nib_lt  input  1  upstream nibble comparator LT for the nibble at nib_sel.
- nib_sel  output  SEL_W  index of the nibble pair being compared; NIBBLES-1 = most significant.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when results are valid.
- GT  output  1  registered result, A > B.
- EQ  output  1  registered result, A == B.
- LT  output  1  registered result, A < B.
- err  output  1  registered flag: upstream nibble result was not one-hot.

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE; nib_sel=0; busy=0; done=0; GT=EQ=LT=0; err=0. Reset applies from any state, including mid-SCAN, and discards the comparison in progress.
- FSM states:
  - IDLE: busy=0, done=0. On start=1: nib_sel<=NIBBLES-1; GT,EQ,LT,err<=0; go to SCAN. Otherwise hold all outputs; results persist indefinitely.
  - SCAN: busy=1. Each cycle, sample nib_gt/eq/lt (upstream sees the current nib_sel).
    - Exactly nib_gt=1: GT<=1, go to DONE.
    - Exactly nib_lt=1: LT<=1, go to DONE.
    - Exactly nib_eq=1 and nib_sel==0: EQ<=1, go to DONE.
    - Exactly nib_eq=1 and nib_sel>0: nib_sel<=nib_sel-1, stay in SCAN.
    - Not one-hot (000, 011, 101, 110, 111): err<=1, GT=EQ=LT stay 0, go to DONE.
  - DONE: done=1 for exactly this one cycle, busy=0; nib_sel held; unconditionally return to IDLE.
- Start handling: start is ignored in SCAN and DONE, with no queuing. A start held high continuously re-triggers on the IDLE cycle after each DONE.
- Latency: start sampled at edge 0; k nibbles scanned (1 ≤ k ≤ NIBBLES) occupy cycles 1..k; done is high in cycle k+1.
  - Best case (MSB nibbles differ): 2 cycles from the start edge to done.
  - Worst case (equal words): NIBBLES+1 cycles.
- Result encoding: after done, exactly one of GT/EQ/LT is 1 when err=0; all three are 0 when err=1. Results change only at start acceptance (cleared) or at the SCAN→DONE edge.
- nib_sel never underflows: the decrement happens only when nib_sel>0.
- Operand stability: A/B must stay stable from start until done; this block does not register the operands.

Test Plan:
- A=0x9000, B=0x1FFF: start pulse → nib_gt=1 at nib_sel=3; done 2 cycles after start; GT=1, EQ=0, LT=0, err=0; busy high exactly 1 cycle.
- A=0x12A4, B=0x12A7: nibbles 3,2,1 eq, nibble 0 lt → nib_sel steps 3,2,1,0; done at cycle 5; LT=1.
- A=B=0xBEEF: all nibbles eq → done at cycle 5 (NIBBLES+1); EQ=1; nib_sel=0 held in DONE and IDLE.
- Invalid upstream: force nib_gt=nib_lt=1 at nib_sel=2 (after eq at 3) → err=1, GT=EQ=LT=0, done at cycle 3.
- Handshake: start held high for 12 cycles with A=0x1000, B=0x2000 → done pulses at cycles 2, 5, 8, 11 (IDLE re-accept cycle between runs); start mid-SCAN ignored; results cleared on each acceptance.
- Reset mid-operation: rst_n=0 while in SCAN at nib_sel=1 → next edge: busy=0, done=0, nib_sel=0, GT=EQ=LT=err=0; no done pulse follows; a new start after rst_n=1 completes normally.

Source files
------------

// File: rtl/comparatore_seriale_if.sv
// Bus between the serial magnitude comparator, its controller and the upstream nibble comparator.
// The slave side is the comparator itself. The master side is whoever drives start and the nibble results.
interface comparatore_seriale_if #(
    parameter int SEL_W = 2
);
    logic             start;
    logic             nib_gt;
    logic             nib_eq;
    logic             nib_lt;
    logic [SEL_W-1:0] nib_sel;
    logic             busy;
    logic             done;
    logic             GT;
    logic             EQ;
    logic             LT;
    logic             err;

    modport slave (
        input  start, nib_gt, nib_eq, nib_lt,
        output nib_sel, busy, done, GT, EQ, LT, err
    );

    modport master (
        output start, nib_gt, nib_eq, nib_lt,
        input  nib_sel, busy, done, GT, EQ, LT, err
    );
endinterface

// File: rtl/comparatore_seriale.sv
// Serial multi-word magnitude comparator. It scans nibbles MSB first through an external 4-bit comparator
// and stops at the first nibble pair that differs. Results are registered and held until the next start.
module comparatore_seriale #(
    parameter int NIBBLES = 4,
    parameter int SEL_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    comparatore_seriale_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
        logic err;
    } res_t;

    localparam logic [SEL_W-1:0] SEL_MSB = SEL_W'(NIBBLES - 1);

    state_t           state, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    res_t             res_q, res_d;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        state_d = state;
        sel_d   = sel_q;
        res_d   = res_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    sel_d   = SEL_MSB;
                    res_d   = '0;
                end
            end
            SCAN: begin
                case ({bus.nib_gt, bus.nib_eq, bus.nib_lt})
                    3'b100: begin
                        res_d.gt = 1'b1;
                        state_d  = DONE;
                    end
                    3'b001: begin
                        res_d.lt = 1'b1;
                        state_d  = DONE;
                    end
                    3'b010: begin
                        // Equal nibble: finish on the LSB, otherwise move to the next lower nibble.
                        if (sel_q == '0) begin
                            res_d.eq = 1'b1;
                            state_d  = DONE;
                        end else begin
                            sel_d = sel_q - SEL_W'(1);
                        end
                    end
                    default: begin
                        res_d.err = 1'b1;
                        state_d   = DONE;
                    end
                endcase
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments, so every flop samples the values from before this edge.
        if (!rst_n) begin
            state <= IDLE;
            sel_q <= '0;
            res_q <= '0;
        end else begin
            state <= state_d;
            sel_q <= sel_d;
            res_q <= res_d;
        end
    end

    assign bus.nib_sel = sel_q;
    assign bus.busy    = (state == SCAN);
    assign bus.done    = (state == DONE);
    assign bus.GT      = res_q.gt;
    assign bus.EQ      = res_q.eq;
    assign bus.LT      = res_q.lt;
    assign bus.err     = res_q.err;

endmodule

// File: tb/tb_comparatore_seriale.sv
// Directed bench for comparatore_seriale. A behavioural 4-bit comparator feeds the nibble results.
// A nibble result can be overridden to inject results that are not one-hot.
module tb_comparatore_seriale;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    comparatore_seriale_if #(.SEL_W(2)) bus ();

    comparatore_seriale #(.NIBBLES(4), .SEL_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Upstream nibble comparator model with an optional forced result at one index.
    logic [15:0] a, b;
    logic [3:0]  an, bn;
    logic        force_en;
    logic [1:0]  force_sel;
    logic [2:0]  force_vec;

    assign an = 4'(a >> (4 * bus.nib_sel));
    assign bn = 4'(b >> (4 * bus.nib_sel));
    assign {bus.nib_gt, bus.nib_eq, bus.nib_lt} =
        (force_en && bus.nib_sel == force_sel) ? force_vec : {an > bn, an == bn, an < bn};

    // {busy, done, GT, EQ, LT, err}
    logic [5:0] st;
    assign st = {bus.busy, bus.done, bus.GT, bus.EQ, bus.LT, bus.err};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        a         = '0;
        b         = '0;
        force_en  = 1'b0;
        force_sel = 2'd0;
        force_vec = 3'b000;
        step();
        step();
        check("reset_status", 8'(st), 8'h00);
        check("reset_sel", 8'(bus.nib_sel), 8'd0);
        rst_n = 1'b1;
        step();
        check("idle_after_reset", 8'(st), 8'h00);

        // MSB nibbles differ: GT, done two cycles after start.
        a = 16'h9000; b = 16'h1FFF;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("gt_scan_status", 8'(st), 8'b100000);
        check("gt_scan_sel", 8'(bus.nib_sel), 8'd3);
        step();
        check("gt_done_status", 8'(st), 8'b011000);
        check("gt_done_sel", 8'(bus.nib_sel), 8'd3);
        step();
        check("gt_idle_hold", 8'(st), 8'b001000);

        // Differs only in the LSB nibble: LT after a full scan.
        a = 16'h12A4; b = 16'h12A7;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            check("lt_scan_status", 8'(st), 8'b100000);
            check("lt_scan_sel", 8'(bus.nib_sel), 8'(i));
            step();
        end
        check("lt_done_status", 8'(st), 8'b010010);
        step();
        check("lt_idle_hold", 8'(st), 8'b000010);

        // Equal words: EQ after NIBBLES+1 cycles, and nib_sel stays at 0 afterwards.
        a = 16'hBEEF; b = 16'hBEEF;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            check("eq_scan_sel", 8'(bus.nib_sel), 8'(i));
            step();
        end
        check("eq_done_status", 8'(st), 8'b010100);
        check("eq_done_sel", 8'(bus.nib_sel), 8'd0);
        step();
        check("eq_idle_status", 8'(st), 8'b000100);
        check("eq_idle_sel", 8'(bus.nib_sel), 8'd0);

        // Upstream reports GT and LT together at nibble 2.
        a = 16'h5555; b = 16'h5555;
        force_en = 1'b1; force_sel = 2'd2; force_vec = 3'b101;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("err_scan3", 8'(st), 8'b100000);
        step();
        check("err_scan2_sel", 8'(bus.nib_sel), 8'd2);
        step();
        check("err_done_status", 8'(st), 8'b010001);
        step();
        check("err_idle_hold", 8'(st), 8'b000001);
        force_en = 1'b0;

        // Start held high: the comparator re-triggers every three cycles.
        a = 16'h1000; b = 16'h2000;
        bus.start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 12) bus.start = 1'b0;
            if (c % 3 == 1)      check("held_scan", 8'(st), 8'b100000);
            else if (c % 3 == 2) check("held_done", 8'(st), 8'b010010);
            else                 check("held_idle", 8'(st), 8'b000010);
        end
        step();
        check("held_released_idle", 8'(st), 8'b000010);

        // Reset during the scan discards the comparison in progress.
        a = 16'h7777; b = 16'h7777;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        check("rst_mid_sel_before", 8'(bus.nib_sel), 8'd1);
        rst_n = 1'b0;
        step();
        check("rst_mid_status", 8'(st), 8'h00);
        check("rst_mid_sel", 8'(bus.nib_sel), 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_no_done", 8'(st), 8'h00);
        end
        a = 16'h0003; b = 16'h0002;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("post_rst_done", 8'(st), 8'b011000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
